palette_writer: RTL

PALETTE_WRITER -- requirements
Module: palette_writer

---
 rtl/vdp_pkg.sv | 19 +
 rtl/rgb_to_ycocg.sv | 87 ++++++++
 rtl/palette_writer.sv | 97 +++++++++
 3 files changed

// File: rtl/vdp_pkg.sv
// Shared palette-path types: YCoCg-R packed entry, palette data width, writer FSM states.
package vdp_pkg;

   localparam int PAL_DW = 24;

   typedef struct packed {
      logic       pad;
      logic [6:0] y;
      logic [7:0] co;
      logic [7:0] cg;
   } ycocg_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      CLEAR = 2'd2
   } wr_state_t;

endpackage

// File: rtl/rgb_to_ycocg.sv
// Three-stage lossless RGB -> YCoCg-R converter on 7-bit components.
// The whole pipeline freezes while stall is high; the index rides along with the data.
module rgb_to_ycocg
   import vdp_pkg::*;
#(
   parameter int AW = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              in_valid,
   input  logic [AW-1:0]     in_index,
   input  logic [PAL_DW-1:0] in_rgb,
   output logic              out_valid,
   output logic [AW-1:0]     out_index,
   output ycocg_t            out_data,
   output logic              any_valid
);

   logic [7:0]    r7, g7, b7;
   logic [7:0]    co_next, co_half, tmp_next, cg_next, cg_half, y_next;
   logic          unused_lsbs;

   logic          s1_valid_reg, s2_valid_reg, s3_valid_reg;
   logic [AW-1:0] s1_index_reg, s2_index_reg, s3_index_reg;
   logic [7:0]    s1_co_reg, s1_g_reg, s1_b_reg;
   logic [7:0]    s2_co_reg, s2_tmp_reg, s2_cg_reg;
   ycocg_t        s3_data_reg;

   // Colour LSBs are dropped by the 7-bit transform.
   assign unused_lsbs = ^{in_rgb[16], in_rgb[8], in_rgb[0]};

   assign r7 = {1'b0, in_rgb[23:17]};
   assign g7 = {1'b0, in_rgb[15:9]};
   assign b7 = {1'b0, in_rgb[7:1]};

   // Arithmetic shifts written as explicit sign replication so mixed-sign
   // expressions cannot silently turn them into logical shifts.
   always_comb begin
      co_next  = r7 - b7;
      co_half  = {s1_co_reg[7], s1_co_reg[7:1]};
      tmp_next = s1_b_reg + co_half;
      cg_next  = s1_g_reg - tmp_next;
      cg_half  = {s2_cg_reg[7], s2_cg_reg[7:1]};
      y_next   = s2_tmp_reg + cg_half;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_reg <= 1'b0;
         s2_valid_reg <= 1'b0;
         s3_valid_reg <= 1'b0;
         s1_index_reg <= '0;
         s2_index_reg <= '0;
         s3_index_reg <= '0;
         s1_co_reg    <= '0;
         s1_g_reg     <= '0;
         s1_b_reg     <= '0;
         s2_co_reg    <= '0;
         s2_tmp_reg   <= '0;
         s2_cg_reg    <= '0;
         s3_data_reg  <= '0;
      end else if (!stall) begin
         s1_valid_reg <= in_valid;
         s1_index_reg <= in_index;
         s1_co_reg    <= co_next;
         s1_g_reg     <= g7;
         s1_b_reg     <= b7;

         s2_valid_reg <= s1_valid_reg;
         s2_index_reg <= s1_index_reg;
         s2_co_reg    <= s1_co_reg;
         s2_tmp_reg   <= tmp_next;
         s2_cg_reg    <= cg_next;

         s3_valid_reg <= s2_valid_reg;
         s3_index_reg <= s2_index_reg;
         s3_data_reg  <= '{pad: 1'b0, y: y_next[6:0], co: s2_co_reg, cg: s2_cg_reg};
      end
   end

   assign out_valid = s3_valid_reg;
   assign out_index = s3_index_reg;
   assign out_data  = s3_data_reg;
   assign any_valid = s1_valid_reg | s2_valid_reg | s3_valid_reg;

endmodule

// File: rtl/palette_writer.sv
// Palette write engine: converts incoming RGB entries to YCoCg-R and writes them during
// blanking, or sweeps the whole palette to black on request.
module palette_writer
   import vdp_pkg::*;
#(
   parameter int PAL_AW = 8
) (
   input  logic              clk_pix,
   input  logic              rst_pix_n,
   input  logic              blank,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [PAL_AW-1:0] s_index,
   input  logic [PAL_DW-1:0] s_rgb,
   input  logic              clear_req,
   output logic              clear_done,
   output logic              busy,
   output logic              pal_we,
   output logic [PAL_AW-1:0] pal_addr,
   output logic [PAL_DW-1:0] pal_data
);

   localparam logic [PAL_AW-1:0] LAST_ADDR = {PAL_AW{1'b1}};

   wr_state_t         state_reg, state_next;
   logic [PAL_AW-1:0] cnt_reg, cnt_next;
   logic              run_reg;

   logic              stall, accept;
   logic              pipe_valid, pipe_any;
   logic [PAL_AW-1:0] pipe_index;
   ycocg_t            pipe_data;

   assign stall   = pipe_valid & ~blank;
   // run_reg keeps s_ready low until the first edge after reset release.
   assign s_ready = run_reg & (state_reg == IDLE) & ~stall;
   assign accept  = s_valid & s_ready;
   assign busy    = pipe_any | (state_reg != IDLE);

   rgb_to_ycocg #(.AW(PAL_AW)) u_conv (
      .clk       (clk_pix),
      .rst_n     (rst_pix_n),
      .stall     (stall),
      .in_valid  (accept),
      .in_index  (s_index),
      .in_rgb    (s_rgb),
      .out_valid (pipe_valid),
      .out_index (pipe_index),
      .out_data  (pipe_data),
      .any_valid (pipe_any)
   );

   always_ff @(posedge clk_pix or negedge rst_pix_n) begin
      if (!rst_pix_n) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         run_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         run_reg   <= 1'b1;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      clear_done = 1'b0;
      pal_we     = 1'b0;
      pal_addr   = pipe_index;
      pal_data   = pipe_data;
      case (state_reg)
         IDLE: begin
            pal_we = pipe_valid & blank;
            if (clear_req) state_next = DRAIN;
         end
         DRAIN: begin
            pal_we = pipe_valid & blank;
            if (!pipe_any) state_next = CLEAR;
         end
         CLEAR: begin
            pal_addr = cnt_reg;
            pal_data = '0;
            if (blank) begin
               pal_we   = 1'b1;
               cnt_next = cnt_reg + 1'b1;
               if (cnt_reg == LAST_ADDR) begin
                  clear_done = 1'b1;
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

endmodule
